// File: rtl/media_blocos_if.sv
// Bus between the zoom-out engine and its surroundings: frame command/status,
// source ROM read port and destination RAM write port.
interface media_blocos_if;
  logic        start;
  logic [2:0]  escala;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        busy;
  logic        done;
  logic        erro;

  modport master (
    output start, escala, rom_data,
    input  rom_addr, wr_addr, wr_data, wr_en, busy, done, erro
  );

  modport slave (
    input  start, escala, rom_data,
    output rom_addr, wr_addr, wr_data, wr_en, busy, done, erro
  );
endinterface

// File: rtl/media_blocos.sv
// Zoom-out engine: averages each escala x escala block of the original image
// (truncating) and writes one reduced pixel per block to the destination RAM.
module media_blocos #(
  parameter int LARGURA_ORIG = 320,
  parameter int ALTURA_ORIG  = 240
) (
  input logic           clk,
  input logic           rst,
  media_blocos_if.slave bus
);
  localparam int AW = 17;
  localparam int XW = (LARGURA_ORIG > 2) ? $clog2(LARGURA_ORIG) : 1;
  localparam int YW = (ALTURA_ORIG > 2) ? $clog2(ALTURA_ORIG) : 1;
  localparam logic [AW-1:0] LARG = AW'(LARGURA_ORIG);

  typedef enum logic [2:0] {OCIOSO, LER, DRENAR, ESCREVER, FIM} estado_t;
  estado_t estado, prox;

  logic [1:0]    sh_q, sh_in;
  logic          escala_ok, inicio_ok;
  logic [XW-1:0] xd, ld_m1;
  logic [YW-1:0] yd, ad_m1;
  logic [1:0]    dx, dy, e_m1;
  logic [11:0]   acc;
  logic [AW-1:0] wa, rom_hold;
  logic [AW-1:0] lin_src, col_src, addr_c;
  logic          erro_q;
  logic          ultimo_bloco, ultimo_pixel;
  logic          wr_en_c, busy_c, done_c;

  function automatic logic [7:0] media_trunc(input logic [11:0] soma, input logic [1:0] sh);
    logic [11:0] q;
    q = soma >> {sh, 1'b0};
    return q[7:0];
  endfunction

  // escala is carried internally as a shift amount: 1->0, 2->1, 4->2
  always_comb begin
    escala_ok = 1'b1;
    sh_in     = 2'd0;
    case (bus.escala)
      3'd1:    sh_in = 2'd0;
      3'd2:    sh_in = 2'd1;
      3'd4:    sh_in = 2'd2;
      default: escala_ok = 1'b0;
    endcase
  end

  assign inicio_ok    = bus.start && (estado == OCIOSO) && escala_ok;
  assign e_m1         = 2'((3'd1 << sh_q) - 3'd1);
  assign ld_m1        = XW'((LARGURA_ORIG >> sh_q) - 1);
  assign ad_m1        = YW'((ALTURA_ORIG >> sh_q) - 1);
  assign ultimo_bloco = (dx == e_m1) && (dy == e_m1);
  assign ultimo_pixel = (xd == ld_m1) && (yd == ad_m1);

  assign lin_src = (AW'(yd) << sh_q) + AW'(dy);
  assign col_src = (AW'(xd) << sh_q) + AW'(dx);
  assign addr_c  = lin_src * LARG + col_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) estado <= OCIOSO;
    else     estado <= prox;
  end

  always_comb begin
    prox    = estado;
    wr_en_c = 1'b0;
    busy_c  = 1'b0;
    done_c  = 1'b0;
    case (estado)
      OCIOSO:   if (inicio_ok) prox = LER;
      LER: begin
        busy_c = 1'b1;
        if (ultimo_bloco) prox = DRENAR;
      end
      DRENAR: begin
        busy_c = 1'b1;
        prox   = ESCREVER;
      end
      ESCREVER: begin
        busy_c  = 1'b1;
        wr_en_c = 1'b1;
        prox    = ultimo_pixel ? FIM : LER;
      end
      FIM: begin
        done_c = 1'b1;
        prox   = OCIOSO;
      end
      default:  prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q     <= 2'd0;
      xd       <= '0;
      yd       <= '0;
      dx       <= 2'd0;
      dy       <= 2'd0;
      acc      <= 12'd0;
      wa       <= '0;
      rom_hold <= '0;
      erro_q   <= 1'b0;
    end else begin
      erro_q <= bus.start && (estado == OCIOSO) && !escala_ok;
      case (estado)
        OCIOSO: if (inicio_ok) begin
          sh_q <= sh_in;
          xd   <= '0;
          yd   <= '0;
          dx   <= 2'd0;
          dy   <= 2'd0;
          acc  <= 12'd0;
          wa   <= '0;
        end
        LER: begin
          rom_hold <= addr_c;
          // ROM data lags its address by one cycle, so the first address adds nothing
          if ((dx != 2'd0) || (dy != 2'd0)) acc <= acc + 12'(bus.rom_data);
          if (dx == e_m1) begin
            dx <= 2'd0;
            dy <= (dy == e_m1) ? 2'd0 : dy + 2'd1;
          end else begin
            dx <= dx + 2'd1;
          end
        end
        DRENAR:   acc <= acc + 12'(bus.rom_data);
        ESCREVER: begin
          wa  <= wa + AW'(1);
          acc <= 12'd0;
          if (xd == ld_m1) begin
            xd <= '0;
            if (!ultimo_pixel) yd <= yd + YW'(1);
          end else begin
            xd <= xd + XW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr = (estado == LER) ? addr_c : rom_hold;
  assign bus.wr_addr  = wa;
  assign bus.wr_data  = media_trunc(acc, sh_q);
  assign bus.wr_en    = wr_en_c;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.erro     = erro_q;
endmodule

// File: tb/tb_media_blocos.sv
// Scoreboard bench for media_blocos on a 16x16 source image: expected writes are
// queued by the stimulus and consumed by a monitor on every wr_en.
module tb_media_blocos;
  localparam int W = 16;
  localparam int H = 16;

  typedef struct {
    logic [16:0] a;
    logic [7:0]  d;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   nwr = 0;
  int   done_cnt = 0;
  int   erro_cnt = 0;
  int   last_wr = 0;
  bit   have_last = 0;
  bit   spacing_on = 0;
  logic [7:0] rom [0:W*H-1];
  exp_t exp_q[$];

  media_blocos_if bus();

  media_blocos #(.LARGURA_ORIG(W), .ALTURA_ORIG(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.rom_data <= (bus.rom_addr < 17'(W*H)) ? rom[bus.rom_addr[7:0]] : 8'h00;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d (t=%0t)", nome, got, req, $time);
    end
  endtask

  task automatic push_model(input int esc);
    int ld, ad, soma;
    ld = W / esc;
    ad = H / esc;
    for (int y = 0; y < ad; y++)
      for (int x = 0; x < ld; x++) begin
        exp_t ex;
        soma = 0;
        for (int by = 0; by < esc; by++)
          for (int bx = 0; bx < esc; bx++)
            soma += rom[(y*esc + by)*W + x*esc + bx];
        ex.a = 17'(y*ld + x);
        ex.d = 8'(soma / (esc*esc));
        exp_q.push_back(ex);
      end
  endtask

  task automatic run_frame(input logic [2:0] esc, input int n_exp, input int cyc_exp, input bit intruso);
    int c0, nwr0, done0, k;
    bit seen;
    @(negedge clk);
    nwr0  = nwr;
    done0 = done_cnt;
    c0    = cyc;
    bus.escala = esc;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1'b1);
    seen = 0;
    k = 0;
    while (!seen && k < cyc_exp + 50) begin
      if (intruso && k == 20) begin
        bus.start  = 1'b1;
        bus.escala = 3'd2;
      end else if (intruso && k == 21) begin
        bus.start  = 1'b0;
        bus.escala = 3'd1;
      end
      if (bus.done) seen = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    bus.start = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout got=no_done required=done within %0d cycles", cyc_exp + 50);
    end else begin
      chk("frame_cycles", cyc - c0 + 1, cyc_exp);
    end
    repeat (5) @(negedge clk);
    chk("frame_writes", nwr - nwr0, n_exp);
    chk("done_once", done_cnt - done0, 1);
    chk("busy_after_done", bus.busy, 1'b0);
  endtask

  initial begin
    fork
      begin : monitor
        exp_t ex;
        forever begin
          @(negedge clk);
          if (!rst) begin
            if (bus.wr_en) begin
              if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write got addr=%0d data=%0d required no write", bus.wr_addr, bus.wr_data);
              end else begin
                ex = exp_q.pop_front();
                chk("wr_addr", bus.wr_addr, ex.a);
                chk("wr_data", bus.wr_data, ex.d);
              end
              if (spacing_on && have_last) chk("wr_spacing", cyc - last_wr, 18);
              last_wr   = cyc;
              have_last = 1;
              nwr++;
            end
            if (bus.done) begin
              done_cnt++;
              chk("queue_empty_at_done", exp_q.size(), 0);
              chk("busy_at_done", bus.busy, 1'b0);
            end
            if (bus.erro) erro_cnt++;
          end
        end
      end
    join_none

    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.escala = 3'd0;
    for (int i = 0; i < W*H; i++) rom[i] = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_erro", bus.erro, 0);

    // escala=2, constant 100: 64 writes of 100, 64*6+2 cycles
    for (int i = 0; i < W*H; i++) rom[i] = 8'd100;
    push_model(2);
    run_frame(3'd2, 64, 386, 0);

    // escala=2, block (0,0) = 10,20,30,41 -> 101>>2 = 25, rest 0
    for (int i = 0; i < W*H; i++) rom[i] = 8'd0;
    rom[0] = 8'd10; rom[1] = 8'd20; rom[W] = 8'd30; rom[W+1] = 8'd41;
    begin
      exp_t ex;
      for (int i = 0; i < 64; i++) begin
        ex.a = 17'(i);
        ex.d = (i == 0) ? 8'd25 : 8'd0;
        exp_q.push_back(ex);
      end
    end
    run_frame(3'd2, 64, 386, 0);

    // escala=4, all 255: 4080>>4 = 255, 16*18+2 cycles, writes every 18 cycles
    for (int i = 0; i < W*H; i++) rom[i] = 8'd255;
    push_model(4);
    spacing_on = 1;
    have_last  = 0;
    run_frame(3'd4, 16, 290, 0);
    spacing_on = 0;

    // escala=1, ROM[a] = a[7:0]: identity copy
    for (int i = 0; i < W*H; i++) rom[i] = 8'(i);
    push_model(1);
    run_frame(3'd1, 256, 770, 0);

    // illegal escala=3: one-cycle erro, nothing else
    begin
      int e0, n0;
      e0 = erro_cnt;
      n0 = nwr;
      @(negedge clk);
      bus.escala = 3'd3;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("erro_pulse", bus.erro, 1'b1);
      chk("erro_busy", bus.busy, 1'b0);
      @(negedge clk);
      chk("erro_falls", bus.erro, 1'b0);
      repeat (5) @(negedge clk);
      chk("erro_count", erro_cnt - e0, 1);
      chk("erro_no_writes", nwr - n0, 0);
      chk("erro_idle", bus.busy, 1'b0);
    end

    // start while busy and escala change mid-frame are ignored
    for (int i = 0; i < W*H; i++) rom[i] = 8'((i * 7) ^ (i >> 3));
    push_model(2);
    run_frame(3'd2, 64, 386, 1);

    // async reset while yd=5 at escala=2, then a fresh full frame
    for (int i = 0; i < W*H; i++) rom[i] = 8'd100;
    begin
      int n0, d0, k;
      push_model(2);
      n0 = nwr;
      @(negedge clk);
      bus.escala = 3'd2;
      bus.start  = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      k = 0;
      while (nwr - n0 < 40 && k < 400) begin
        @(negedge clk);
        k++;
      end
      chk("pre_reset_writes", nwr - n0, 40);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_rom_addr", bus.rom_addr, 0);
      chk("midrst_wr_addr", bus.wr_addr, 0);
      chk("midrst_wr_data", bus.wr_data, 0);
      chk("midrst_wr_en", bus.wr_en, 0);
      chk("midrst_busy", bus.busy, 0);
      chk("midrst_done", bus.done, 0);
      exp_q.delete();
      n0 = nwr;
      d0 = done_cnt;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      chk("postrst_no_writes", nwr - n0, 0);
      chk("postrst_no_done", done_cnt - d0, 0);
      chk("postrst_idle", bus.busy, 0);
    end
    push_model(2);
    run_frame(3'd2, 64, 386, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
